// File: rtl/mcycle_pkg.sv
// Shared types and constants for the MCycle issue sequencer.
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int unsigned WDOG_CYCLES_DEF = 80;

endpackage

// File: rtl/mcycle_wdog.sv
// Watchdog for the issue sequencer: counts cycles spent waiting on MCycle
// and flags the terminal count. Used only when MCYCLE_WATCHDOG_EN is defined.
module mcycle_wdog #(
  parameter int unsigned LIMIT = 80
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Cycle counter: cleared at request acceptance, advances while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Hit during the LIMIT-th waiting cycle so the abort takes effect at its end.
  assign hit = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mcycle_issue.sv
// Issue sequencer between decode/execute and the MCycle multiply/divide unit.
// Holds one request's operands stable, drives Start until Busy, captures Result
// and presents it for write-back while stalling the pipeline.
// Optional watchdog abort: define MCYCLE_WATCHDOG_EN.
module mcycle_issue
  import mcycle_pkg::*;
#(
  parameter int unsigned width       = 32,
  parameter int unsigned RD_W        = 4,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic             ReqOp,
  input  logic [width-1:0] ReqA,
  input  logic [width-1:0] ReqB,
  input  logic [RD_W-1:0]  ReqRd,
  output logic             Start,
  output logic             MCycleOp,
  output logic [width-1:0] Operand1,
  output logic [width-1:0] Operand2,
  input  logic [width-1:0] Result,
  input  logic             Busy,
  output logic             Stall,
  output logic             WbValid,
  input  logic             WbReady,
  output logic [RD_W-1:0]  WbRd,
  output logic [width-1:0] WbData,
  output logic             WbErr
);

  state_t state, nxt;
  logic   accept;
  logic   waiting;
  logic   timeout;
  logic   finish;

  assign accept  = (state == IDLE) && ReqValid;
  assign waiting = (state == LAUNCH) || (state == RUN);
  assign finish  = (state == RUN) && !Busy;

`ifdef MCYCLE_WATCHDOG_EN
  mcycle_wdog #(
    .LIMIT(WDOG_CYCLES)
  ) u_wdog (
    .clk(CLK),
    .rst(RESET),
    .clr(accept),
    .en (waiting),
    .hit(timeout)
  );
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign timeout     = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state and Start; a normal completion wins over a same-cycle timeout.
  always_comb begin
    nxt   = state;
    Start = 1'b0;
    case (state)
      IDLE:   if (ReqValid) nxt = LAUNCH;
      LAUNCH: begin
        if (timeout) begin
          nxt = DONE;
        end else begin
          Start = 1'b1;
          if (Busy) nxt = RUN;
        end
      end
      RUN:    if (!Busy || timeout) nxt = DONE;
      DONE:   if (WbReady) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign ReqReady = (state == IDLE);
  assign Stall    = (ReqValid && !ReqReady) || (state != IDLE);
  assign WbValid  = (state == DONE);

  // Operand latches at acceptance; result capture on RUN->DONE or abort.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MCycleOp <= OP_MUL;
      Operand1 <= '0;
      Operand2 <= '0;
      WbRd     <= '0;
      WbData   <= '0;
    end else begin
      if (accept) begin
        MCycleOp <= ReqOp;
        Operand1 <= ReqA;
        Operand2 <= ReqB;
        WbRd     <= ReqRd;
      end
      if (finish) begin
        WbData <= Result;
      end else if (waiting && timeout) begin
        WbData <= '0;
      end
    end
  end

`ifdef MCYCLE_WATCHDOG_EN
  // Error flag: set by an abort, cleared when the write-back is taken.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WbErr <= 1'b0;
    end else if (finish) begin
      WbErr <= 1'b0;
    end else if (waiting && timeout) begin
      WbErr <= 1'b1;
    end else if ((state == DONE) && WbReady) begin
      WbErr <= 1'b0;
    end
  end
`else
  assign WbErr = 1'b0;
`endif

endmodule

// File: doc/mcycle_issue.md
Name: mcycle_issue

Overview:
- Sequencer between the CPU decode/execute stage and the MCycle multi-cycle multiply/divide unit.
- Accepts one multiply/divide request and holds its operands stable. Drives MCycle's Start/MCycleOp/Operand1/Operand2, waits out Busy, captures Result and presents it for register write-back.
- Stalls the pipeline for the whole operation, so MCycle never sees operands change mid-run.

Parameters:
- width, 32, datapath width; must match the MCycle instance.
- RD_W, 4, destination-register index width.
- WDOG_CYCLES, 80, watchdog limit in cycles; used only with the optional feature.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ReqValid  in  1  decode stage presents a MUL/DIV request.
- ReqReady  out  1  request accepted this cycle.
- ReqOp  in  1  0=multiply, 1=divide; same encoding as MCycleOp.
- ReqA  in  width  first operand (multiplicand or dividend).
- ReqB  in  width  second operand (multiplier or divisor).
- ReqRd  in  RD_W  destination register index.
- Start  out  1  to MCycle.
- MCycleOp  out  1  to MCycle.
- Operand1  out  width  to MCycle; registered copy of ReqA.
- Operand2  out  width  to MCycle; registered copy of ReqB.
- Result  in  width  from MCycle.
- Busy  in  1  from MCycle.
- Stall  out  1  freeze the upstream pipeline.
- WbValid  out  1  write-back data valid.
- WbReady  in  1  write-back accepted.
- WbRd  out  RD_W  destination index.
- WbData  out  width  captured Result.
- WbErr  out  1  watchdog abort; constant 0 when the feature is compiled out.

Behaviour:
- Reset values (async, immediate): state=IDLE. ReqReady=1; all of Start, Stall, WbValid and WbErr=0. MCycleOp, Operand1, Operand2, WbRd and WbData=0.
- ReqReady=1 only in IDLE. Stall = ReqValid&&!ReqReady, OR state!=IDLE.
- IDLE:
  - On ReqValid: latch ReqOp/ReqA/ReqB/ReqRd into MCycleOp/Operand1/Operand2/WbRd.
  - Next state LAUNCH.
- LAUNCH:
  - Start=1.
  - If Busy==1 is sampled, go to RUN; otherwise stay. Start is held high until MCycle acknowledges with Busy.
- RUN:
  - Start=0; operands stay frozen.
  - On the first cycle Busy==0 is sampled, register Result into WbData and go to DONE.
- DONE:
  - WbValid=1; WbData and WbRd stay stable.
  - If WbReady, return to IDLE next cycle; otherwise hold.
- Latency: accept → LAUNCH is 1 cycle. WbValid rises 1 cycle after Busy falls.
- Minimum occupancy is 4 cycles plus the MCycle run. Back-to-back requests incur one IDLE bubble.
- A request arriving in DONE is not accepted even if WbReady=1. ReqReady stays 0 until IDLE.
- Operand latches update only at acceptance. Upstream may change ReqA/ReqB after the handshake without effect.
- Result is captured only on the RUN→DONE transition. MCycle's Result is ignored at all other times.
- RESET asserted in any state: return to IDLE within the same cycle and clear all outputs to reset values. MCycle shares RESET, so no drain is needed.
- Busy already high in IDLE (spurious): ignored. The request handshake is unaffected, and LAUNCH proceeds straight to RUN on the next cycle.
- Divide-by-zero is passed through unmodified; the Result semantics belong to MCycle.

Optional Feature:
- Macro: MCYCLE_WATCHDOG_EN.
- With the macro defined:
  - A counter clears on acceptance and increments every cycle in LAUNCH and RUN.
  - On reaching WDOG_CYCLES: force Start=0, go to DONE with WbErr=1 and WbData=0.
  - WbErr clears when leaving DONE.
- Without the macro: no counter; WbErr tied to 0; LAUNCH and RUN wait indefinitely.

Decomposition:
- Package mcycle_pkg:
  - state enum {IDLE, LAUNCH, RUN, DONE};
  - op constants OP_MUL=1'b0, OP_DIV=1'b1;
  - default WDOG_CYCLES.
- Sub-module mcycle_wdog (counter plus terminal-count compare), instantiated only under MCYCLE_WATCHDOG_EN.

Test Plan:
- Multiply 6×3: with the real MCycle, pulse ReqValid with ReqA=6, ReqB=3, ReqOp=0 → Start held until Busy, then WbValid with WbData=18 and the correct WbRd; Stall high throughout.
- Divide 6/3: ReqOp=1 → WbData=2 (quotient). Then ReqA=0xFCDEFFFF, ReqB=0xFAFFFFFF multiply → WbData=0x08210001 (low word).
- Backpressure: hold WbReady=0 for 10 cycles after WbValid → WbData/WbRd stable, ReqReady=0, and a new ReqValid is not accepted until one cycle after WbReady.
- Operand isolation: change ReqA/ReqB every cycle after acceptance of 0xFCDEFFFD×2 → WbData=0xF9BDFFFA.
- Reset mid-RUN: assert RESET 5 cycles into Busy → Start, Stall and WbValid go 0 immediately; the next request completes normally.
- Watchdog (macro defined): a model MCycle that never raises Busy → after WDOG_CYCLES, WbValid=1, WbErr=1, WbData=0, and Start drops.
